// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the data-memory responder
//
// Purpose: holds the responder state encoding, the pending-operation type,
// the block/address/counter widths and the counter load helper.
// Ports: none (package).
// Build option: DMEM_RESPONDER_CLEAR_ON_RESET_EN (used by dmem_block_array).
package dmem_pkg;

  localparam int BLOCK_W = 32;
  localparam int BADDR_W = 6;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Counter value loaded at capture so the commit lands on edge E_LATENCY.
  function automatic logic [CNT_W-1:0] cnt_load(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/dmem_block_array.sv
// rtl/dmem_block_array.sv - block storage for the data-memory responder
//
// Purpose: DEPTH_BLOCKS x BLOCK_W storage with a synchronous write port and a
// combinational read port; the responder samples rdata on the commit edge.
// Ports:
//   clk    - clock, write happens on the rising edge
//   rst_n  - async active-low reset, present only when
//            DMEM_RESPONDER_CLEAR_ON_RESET_EN is defined (clears all blocks)
//   we     - write enable (commit of a write access)
//   addr   - block address for both read and write
//   wdata  - block to store
//   rdata  - block currently held at addr
// Build option: DMEM_RESPONDER_CLEAR_ON_RESET_EN zeroes storage on reset;
// otherwise contents persist across reset.
module dmem_block_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 64
) (
  input  logic               clk,
`ifdef DMEM_RESPONDER_CLEAR_ON_RESET_EN
  input  logic               rst_n,
`endif
  input  logic               we,
  input  logic [BADDR_W-1:0] addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [DEPTH_BLOCKS];

  assign rdata = mem[addr];

`ifdef DMEM_RESPONDER_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_BLOCKS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end
`endif

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency block responder for a cache refill/writeback port
//
// Purpose: captures one block read or write request, holds BUSYWAIT for
// LATENCY edges, commits the access to dmem_block_array, then drops
// BUSYWAIT for exactly one DONE cycle before accepting the next request.
// Ports:
//   CLK       - clock, rising edge
//   RESET     - async active-low reset
//   READ      - block-read request (held until BUSYWAIT falls)
//   WRITE     - block-write request (wins over READ when both high)
//   ADDRESS   - block address
//   WRITEDATA - write block, byte 0 in [7:0]
//   READDATA  - last committed read block
//   BUSYWAIT  - stall to the cache
// Build option: DMEM_RESPONDER_CLEAR_ON_RESET_EN also zeroes storage on reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY      = 5,
  parameter int DEPTH_BLOCKS = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [BADDR_W-1:0] ADDRESS,
  input  logic [BLOCK_W-1:0] WRITEDATA,
  output logic [BLOCK_W-1:0] READDATA,
  output logic               BUSYWAIT
);

  localparam logic [CNT_W-1:0] CNT_LOAD = cnt_load(LATENCY);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BADDR_W-1:0] lat_addr;
  logic [BLOCK_W-1:0] lat_data;
  op_t                lat_op;
  logic               capture;
  logic               commit;
  logic               busy_int;
  logic [BLOCK_W-1:0] arr_rdata;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_int  = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        // Stall in the request cycle itself so the cache never runs ahead.
        busy_int = READ | WRITE;
        if (READ | WRITE) begin
          capture   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy_int = 1'b1;
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Requests seen here are the cache still holding the old one.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset gates the stall directly so it drops without waiting for a clock.
  assign BUSYWAIT = RESET & busy_int;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_op   <= OP_READ;
      READDATA <= '0;
    end else begin
      if (capture) begin
        cnt      <= CNT_LOAD;
        lat_addr <= ADDRESS;
        lat_data <= WRITEDATA;
        lat_op   <= WRITE ? OP_WRITE : OP_READ;
      end else if ((state == BUSY) && !commit) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && (lat_op == OP_READ)) begin
        READDATA <= arr_rdata;
      end
    end
  end

  dmem_block_array #(
    .DEPTH_BLOCKS(DEPTH_BLOCKS)
  ) u_array (
    .clk  (CLK),
`ifdef DMEM_RESPONDER_CLEAR_ON_RESET_EN
    .rst_n(RESET),
`endif
    .we   (commit && (lat_op == OP_WRITE)),
    .addr (lat_addr),
    .wdata(lat_data),
    .rdata(arr_rdata)
  );

endmodule
